button_events: RTL

Event generator directly downstream of the debouncer. Consumes the debouncer's clean, active-low button level and turns it into single-cycle press and release strobes, a long-press strobe, and a wrapping press counter that drives the LED display logic. Optionally adds auto-repeat strobes while the button stays held after a long press.

---
 rtl/button_pkg.sv | 16 +
 rtl/cycle_timer.sv | 38 +++
 rtl/button_events.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// button_pkg
// Shared definitions for the button front-end blocks (debouncer, event
// generator and later button logic).
//   button_state_t : event FSM encoding (IDLE=0, HELD=1, LONG=2)
//   STROBE_W       : width of every one-cycle event strobe
package button_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } button_state_t;

  localparam int STROBE_W = 1;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer
// Up-counter used to time how long the button has been held. It is cleared
// synchronously, counts while enabled and stops at the terminal value.
// Ports:
//   clk      in  : system clock
//   rst      in  : synchronous active-low reset
//   clr      in  : synchronous clear to 0 (wins over en)
//   en       in  : count enable
//   terminal in  : terminal value, WIDTH bits
//   done     out : high while the count equals terminal
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] value;

  assign done = (value == terminal);

  // Holding at the terminal value keeps the count from ever running past it,
  // even if the controller leaves the enable high for an extra cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en && !done) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/button_events.sv
// button_events
// Turns the debounced, active-low button level into one-cycle press, release,
// long-press and (optionally) auto-repeat strobes plus a wrapping press count.
// Optional feature macro: BUTTON_EVENTS_REPEAT_EN enables auto-repeat while
// the button stays held after a long press; otherwise rpt is tied to 0.
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous active-low reset
//   sig        in  : debounced button level, 0 = pressed
//   press      out : one-cycle strobe on each press
//   rel        out : one-cycle strobe on each release ("release" is a
//                    reserved word, hence the short name)
//   long_press out : one-cycle strobe once per hold of LONG_CLK_COUNT cycles
//   rpt        out : one-cycle auto-repeat strobe
//   count      out : running press count, COUNT_WIDTH bits, wraps
module button_events
  import button_pkg::*;
#(
  parameter int LONG_CLK_COUNT   = 12000000,
  parameter int REPEAT_CLK_COUNT = 2400000,
  parameter int COUNT_WIDTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig,
  output logic                   press,
  output logic                   rel,
  output logic                   long_press,
  output logic                   rpt,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int TIMER_MAX = (LONG_CLK_COUNT > REPEAT_CLK_COUNT) ?
                             LONG_CLK_COUNT : REPEAT_CLK_COUNT;
  localparam int TW = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TW-1:0] LONG_TERM = TW'(LONG_CLK_COUNT - 1);
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_TERM = TW'(REPEAT_CLK_COUNT - 1);
`endif

  button_state_t          state;
  button_state_t          state_n;
  logic                   prev_sig;
  logic                   press_n;
  logic                   rel_n;
  logic                   long_n;
  logic                   rpt_n;
  logic [COUNT_WIDTH-1:0] count_n;
  logic                   tmr_clr;
  logic                   tmr_en;
  logic [TW-1:0]          tmr_term;
  logic                   tmr_done;

  cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .terminal(tmr_term),
    .done    (tmr_done)
  );

  // State, edge-detect history and all outputs are registered here so every
  // strobe appears in the cycle after the edge that sampled the change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prev_sig   <= 1'b1;
      press      <= 1'b0;
      rel        <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_n;
      prev_sig   <= sig;
      press      <= press_n;
      rel        <= rel_n;
      long_press <= long_n;
      rpt        <= rpt_n;
      count      <= count_n;
    end
  end

  // Next-state and strobe decode. Release is tested before timer expiry so a
  // release landing on the terminal cycle suppresses long_press/rpt.
  always_comb begin
    state_n  = state;
    press_n  = 1'b0;
    rel_n    = 1'b0;
    long_n   = 1'b0;
    rpt_n    = 1'b0;
    count_n  = count;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    tmr_term = LONG_TERM;
    case (state)
      IDLE: begin
        // Timer parked at 0 so a new hold always starts from a clean count.
        tmr_clr = 1'b1;
        if (prev_sig && !sig) begin
          state_n = HELD;
          press_n = 1'b1;
          count_n = count + COUNT_WIDTH'(1);
        end
      end
      HELD: begin
        if (sig) begin
          rel_n   = 1'b1;
          state_n = IDLE;
        end else if (tmr_done) begin
          long_n  = 1'b1;
          tmr_clr = 1'b1;
          state_n = LONG;
        end else begin
          tmr_en = 1'b1;
        end
      end
      LONG: begin
`ifdef BUTTON_EVENTS_REPEAT_EN
        tmr_term = REPEAT_TERM;
        if (sig) begin
          rel_n   = 1'b1;
          state_n = IDLE;
        end else if (tmr_done) begin
          rpt_n   = 1'b1;
          count_n = count + COUNT_WIDTH'(1);
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
`else
        tmr_clr = 1'b1;
        if (sig) begin
          rel_n   = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
